// File: rtl/fm_receiver_hls_mac_pipe.sv
// fm_receiver_hls_mac_pipe: pipelined signed multiply-accumulate engine.
// Windowed sum of products with round-half-up, saturation and overflow flag.
module fm_receiver_hls_mac_pipe #(
    parameter int ID         = 1,
    parameter int NUM_STAGE  = 3,
    parameter int din0_WIDTH = 16,
    parameter int din1_WIDTH = 16,
    parameter int ACC_WIDTH  = 40,
    parameter int dout_WIDTH = 16,
    parameter int SHIFT      = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    input  logic                  in_valid,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    input  logic                  acc_clr,
    input  logic                  acc_last,
    output logic [dout_WIDTH-1:0] dout,
    output logic                  dout_valid,
    output logic                  ovf
);

    localparam int PW = din0_WIDTH + din1_WIDTH;
    localparam int LS = NUM_STAGE - 1;

    localparam logic signed [ACC_WIDTH:0] ONE  = 1;
    localparam logic signed [ACC_WIDTH:0] RND  = (ONE <<< SHIFT) >>> 1;
    localparam logic signed [ACC_WIDTH:0] MAXV = (ONE <<< (dout_WIDTH - 1)) - ONE;
    localparam logic signed [ACC_WIDTH:0] MINV = ~MAXV;

    // Parameter sanity: an illegal configuration elaborates an empty marker block.
    if (NUM_STAGE < 1 || ACC_WIDTH < PW || SHIFT < 0 || SHIFT >= ACC_WIDTH || ID < 0) begin : g_bad_param
    end

    logic signed [PW-1:0] r_prod [NUM_STAGE];
    logic                 r_vld  [NUM_STAGE];
    logic                 r_clr  [NUM_STAGE];
    logic                 r_last [NUM_STAGE];

    logic signed [ACC_WIDTH-1:0]  r_acc;
    logic        [dout_WIDTH-1:0] r_dout;
    logic                         r_dout_valid;
    logic                         r_ovf;

    logic signed [PW-1:0]        w_prod;
    logic signed [ACC_WIDTH-1:0] w_ext;
    logic signed [ACC_WIDTH-1:0] w_acc_next;
    logic signed [ACC_WIDTH:0]   w_t;
    logic signed [ACC_WIDTH:0]   w_r;
    logic                        w_fire;

    assign w_prod = $signed(din0) * $signed(din1);

    // Product pipeline: full-precision product plus side-band flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_STAGE; i++) begin
                r_prod[i] <= '0;
                r_vld[i]  <= 1'b0;
                r_clr[i]  <= 1'b0;
                r_last[i] <= 1'b0;
            end
        end else if (ce) begin
            r_prod[0] <= w_prod;
            r_vld[0]  <= in_valid;
            r_clr[0]  <= acc_clr;
            r_last[0] <= acc_last;
            for (int i = 1; i < NUM_STAGE; i++) begin
                r_prod[i] <= r_prod[i-1];
                r_vld[i]  <= r_vld[i-1];
                r_clr[i]  <= r_clr[i-1];
                r_last[i] <= r_last[i-1];
            end
        end
    end

    // Next accumulator value and the rounded, shifted candidate result.
    always_comb begin
        w_ext      = r_prod[LS];
        w_acc_next = r_acc;
        if (r_vld[LS]) begin
            if (r_clr[LS]) w_acc_next = w_ext;
            else           w_acc_next = r_acc + w_ext;
        end
        w_t    = w_acc_next;
        w_t    = w_t + RND;
        w_r    = w_t >>> SHIFT;
        w_fire = r_vld[LS] & r_last[LS];
    end

    // Accumulator and saturating output register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc        <= '0;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
            r_ovf        <= 1'b0;
        end else if (ce) begin
            r_acc        <= w_acc_next;
            r_dout_valid <= w_fire;
            if (w_fire) begin
                if (w_r > MAXV) begin
                    r_dout <= MAXV[dout_WIDTH-1:0];
                    r_ovf  <= 1'b1;
                end else if (w_r < MINV) begin
                    r_dout <= MINV[dout_WIDTH-1:0];
                    r_ovf  <= 1'b1;
                end else begin
                    r_dout <= w_r[dout_WIDTH-1:0];
                    r_ovf  <= 1'b0;
                end
            end
        end
    end

    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;
    assign ovf        = r_ovf;

endmodule

// File: tb/tb_fm_receiver_hls_mac_pipe.sv
// tb_fm_receiver_hls_mac_pipe: directed plus random checks of the MAC engine
// against an arithmetic model of the windowed, rounded, saturated sum.
module tb_fm_receiver_hls_mac_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        ce;
    logic        in_valid;
    logic [15:0] din0;
    logic [15:0] din1;
    logic        acc_clr;
    logic        acc_last;
    logic [15:0] dout;
    logic        dout_valid;
    logic        ovf;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {
        int          due;
        logic [15:0] d;
        logic        o;
    } exp_t;

    exp_t   q[$];
    longint m_acc   = 0;
    int     edge_n  = 0;
    logic [15:0] e_dout = '0;
    logic        e_ovf  = 1'b0;
    logic        e_dv   = 1'b0;

    fm_receiver_hls_mac_pipe dut (
        .clk        (clk),
        .reset      (reset),
        .ce         (ce),
        .in_valid   (in_valid),
        .din0       (din0),
        .din1       (din1),
        .acc_clr    (acc_clr),
        .acc_last   (acc_last),
        .dout       (dout),
        .dout_valid (dout_valid),
        .ovf        (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic longint wrap40(input longint x);
        return (x <<< 24) >>> 24;
    endfunction

    // Rounded, saturated result of a finished sum, as plain arithmetic.
    function automatic exp_t result_of(input longint acc, input int due);
        exp_t   e;
        longint r;
        r     = (acc + 64'sd16384) >>> 15;
        e.due = due;
        if (r > 32767) begin
            e.d = 16'h7fff;
            e.o = 1'b1;
        end else if (r < -32768) begin
            e.d = 16'h8000;
            e.o = 1'b1;
        end else begin
            e.d = r[15:0];
            e.o = 1'b0;
        end
        return e;
    endfunction

    // One clock: drive inputs, update model, check all outputs after the edge.
    task automatic cyc(input logic r, input logic e, input logic v,
                       input logic [15:0] a, input logic [15:0] b,
                       input logic c, input logic l);
        longint p;
        exp_t   x;
        reset    = r;
        ce       = e;
        in_valid = v;
        din0     = a;
        din1     = b;
        acc_clr  = c;
        acc_last = l;
        if (!r && e && v) begin
            p = longint'($signed(a)) * longint'($signed(b));
            m_acc = c ? p : wrap40(m_acc + p);
            if (l) q.push_back(result_of(m_acc, edge_n + 4));
        end
        @(posedge clk);
        #1;
        if (r) begin
            q.delete();
            m_acc  = 0;
            e_dout = '0;
            e_ovf  = 1'b0;
            e_dv   = 1'b0;
        end else if (e) begin
            edge_n++;
            e_dv = 1'b0;
            if (q.size() > 0 && q[0].due == edge_n) begin
                x      = q.pop_front();
                e_dout = x.d;
                e_ovf  = x.o;
                e_dv   = 1'b1;
            end
        end
        chk("dout_valid", 64'(dout_valid), 64'(e_dv));
        chk("dout", 64'(dout), 64'(e_dout));
        chk("ovf", 64'(ovf), 64'(e_ovf));
    endtask

    task automatic idle();
        cyc(1'b0, 1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    endtask

    task automatic tap(input logic [15:0] a, input logic [15:0] b,
                       input logic c, input logic l);
        cyc(1'b0, 1'b1, 1'b1, a, b, c, l);
    endtask

    // Wait a bounded number of idle cycles for a result; check known constants.
    task automatic expect_out(input string tag, input logic [15:0] d,
                              input logic o, input int wait_n);
        int k = 0;
        while (!dout_valid && k < 12) begin
            idle();
            k++;
        end
        chk({tag, "_lat"}, 64'(k), 64'(wait_n));
        chk({tag, "_dout"}, 64'(dout), 64'(d));
        chk({tag, "_ovf"}, 64'(ovf), 64'(o));
    endtask

    initial begin
        reset    = 1'b1;
        ce       = 1'b0;
        in_valid = 1'b0;
        din0     = '0;
        din1     = '0;
        acc_clr  = 1'b0;
        acc_last = 1'b0;

        // Reset applies with ce low.
        cyc(1'b1, 1'b0, 1'b1, 16'h1234, 16'h5678, 1'b1, 1'b1);
        idle();

        // Single tap: 16384*16384 -> 8192, one cycle wide.
        tap(16'd16384, 16'd16384, 1'b1, 1'b1);
        expect_out("t1", 16'd8192, 1'b0, 3);
        idle();
        chk("t1_pulse", 64'(dout_valid), 64'd0);

        // Saturation and the most negative in-range result.
        tap(16'h8000, 16'h8000, 1'b1, 1'b1);
        expect_out("t2a", 16'h7fff, 1'b1, 3);
        tap(16'h7fff, 16'h8000, 1'b1, 1'b1);
        expect_out("t2b", 16'h8001, 1'b0, 3);

        // Three taps across an in_valid gap.
        tap(16'd1000, 16'd2000, 1'b1, 1'b0);
        idle();
        tap(-16'sd500, 16'd3000, 1'b1 ^ 1'b1, 1'b0);
        tap(16'd7, 16'd4, 1'b0, 1'b1);
        expect_out("t3", 16'd15, 1'b0, 3);

        // Rounding boundaries.
        tap(16'd128, 16'd128, 1'b1, 1'b1);
        expect_out("t4a", 16'd1, 1'b0, 3);
        tap(-16'sd128, 16'd128, 1'b1, 1'b1);
        expect_out("t4b", 16'd0, 1'b0, 3);
        tap(16'd127, 16'd128, 1'b1, 1'b1);
        expect_out("t4c", 16'd0, 1'b0, 3);

        // ce stall of 5 cycles after the second tap; junk inputs are ignored.
        tap(16'd1000, 16'd2000, 1'b1, 1'b0);
        idle();
        tap(-16'sd500, 16'd3000, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++)
            cyc(1'b0, 1'b0, 1'b1, 16'($urandom), 16'($urandom), 1'b1, 1'b1);
        tap(16'd7, 16'd4, 1'b0, 1'b1);
        expect_out("t5", 16'd15, 1'b0, 3);

        // Reset mid-sum discards the partial sum and in-flight samples.
        tap(16'd20000, 16'd20000, 1'b1, 1'b0);
        tap(16'd20000, 16'd20000, 1'b0, 1'b1);
        cyc(1'b1, 1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        tap(16'd16384, 16'd16384, 1'b1, 1'b1);
        expect_out("t6", 16'd8192, 1'b0, 3);

        // Random traffic with stalls, gaps, boundary operands and rare resets.
        for (int i = 0; i < 600; i++) begin
            logic [15:0] a;
            logic [15:0] b;
            a = 16'($urandom);
            b = 16'($urandom);
            if ($urandom_range(0, 7) == 0) a = 16'h8000;
            if ($urandom_range(0, 7) == 0) b = 16'h8000;
            cyc(($urandom_range(0, 120) == 0),
                ($urandom_range(0, 4) != 0),
                ($urandom_range(0, 3) != 0),
                a, b,
                ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 2) == 0));
        end
        for (int i = 0; i < 8; i++) idle();
        chk("drain", 64'(q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/fm_receiver_hls_mac_pipe.md
Name: fm_receiver_hls_mac_pipe

Overview:
- Parametrised, pipelined signed multiply-accumulate engine. It is the next generation of the single-cycle 16x16 signed multiplier core.
- Computes a windowed sum of products for the FIR, decimation and de-emphasis filters in the FM receiver datapath.
- Outputs each sum rounded and saturated to the output width, with an overflow flag.
- Clock-enable semantics match the other HLS-generated arithmetic cores.

Parameters:
- ID, 1, instance identifier; no functional effect.
- NUM_STAGE, 3, multiplier pipeline depth in registers, input register included; minimum 1.
- din0_WIDTH, 16, signed operand A width.
- din1_WIDTH, 16, signed operand B width.
- ACC_WIDTH, 40, signed accumulator width; must be >= din0_WIDTH+din1_WIDTH.
- dout_WIDTH, 16, signed result width.
- SHIFT, 15, right shift applied to the accumulator before saturation; 0 to ACC_WIDTH-1.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- ce  in  1  clock enable; when 0, all state holds.
- in_valid  in  1  din0/din1/acc_clr/acc_last carry a sample.
- din0  in  din0_WIDTH  signed operand A (sample).
- din1  in  din1_WIDTH  signed operand B (coefficient).
- acc_clr  in  1  first sample of a new sum.
- acc_last  in  1  last sample of the sum; triggers an output.
- dout  out  dout_WIDTH  rounded, saturated result.
- dout_valid  out  1  dout holds a new result.
- ovf  out  1  result was saturated; qualified by dout_valid.

Behaviour:
- Reset: clears all pipeline valid bits, the accumulator, dout, dout_valid and ovf to 0 on the first edge with reset=1, regardless of ce. In-flight samples and a partial sum are discarded; no dout_valid is produced for them.
- Advance rule: state advances only on edges with ce=1. With ce=0, every register (dout/dout_valid/ovf included) holds. Consumers qualify dout_valid with ce.
- Product pipeline: NUM_STAGE registers carry the full-precision signed product (din0_WIDTH+din1_WIDTH bits) plus in_valid/acc_clr/acc_last side-band.
- Accumulate stage: applies the pipeline-output sample as follows.
  - If the sample is not valid, acc holds and its flags are ignored.
  - If valid with acc_clr=1, acc_next = sext(product).
  - If valid with acc_clr=0, acc_next = acc + sext(product), wrapping modulo 2^ACC_WIDTH (no accumulator saturation).
  - acc_clr and acc_last together form a one-tap sum.
- Output stage, on the same edge as the accumulate when the sample is valid with acc_last=1:
  - t = acc_next + 2^(SHIFT-1), evaluated in ACC_WIDTH+1 bits; rounding is half toward +inf, and no add when SHIFT=0.
  - r = t >>> SHIFT (arithmetic shift).
  - If r > 2^(dout_WIDTH-1)-1, dout = max and ovf=1. If r < -2^(dout_WIDTH-1), dout = min and ovf=1. Otherwise dout = r and ovf=0.
  - dout_valid=1.
- On any other ce=1 edge: dout_valid=0; dout and ovf hold their last values.
- Latency: NUM_STAGE+1 ce-enabled edges from sampling acc_last to dout_valid=1.
- Throughput: one sample per ce cycle. Back-to-back sums are allowed: an acc_clr sample may directly follow an acc_last sample.
- Samples arriving before the first acc_clr after reset accumulate onto 0.
- in_valid gaps inside a sum are permitted and leave acc unchanged.
- acc_last with no preceding acc_clr continues the current sum.

Test Plan (defaults: NUM_STAGE=3, latency 4):
1. Single tap: din0=16384, din1=16384, clr=last=1 -> dout=8192, ovf=0, dout_valid high 4 edges later, exactly one cycle wide.
2. Saturation: din0=-32768, din1=-32768 one-tap -> r=32768, so dout=32767, ovf=1. Then 32767*-32768 -> dout=-32767, ovf=0.
3. Three-tap sum across an in_valid gap: (1000,2000) clr, idle, (-500,3000), (7,4) last -> acc=500028, dout=15.
4. Rounding boundary: one-tap 128*128 -> dout=1. One-tap -128*128 -> dout=0. One-tap 127*128 -> dout=0.
5. ce stall: in test 3, drop ce for 5 cycles after the second tap -> dout=15, dout_valid 5 clocks later than in test 3, outputs frozen during the stall.
6. Reset mid-sum: reset for one cycle after two taps, then one-tap 16384*16384 -> no result for the aborted sum; dout=8192.
